// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential radix-2 Booth multiplier.
`timescale 1ns/1ps
package mul_pkg;
    localparam int MUL_W     = 32;
    localparam int MUL_STEPS = 32;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_e;
endpackage

// File: rtl/bk_adder32.sv
// 32-bit Brent-Kung parallel-prefix adder with carry-in and carry-out.
`timescale 1ns/1ps
module bk_adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] prop;
    logic [31:0] gg;
    logic [31:0] pp;

    // gg[i] ends up as the carry out of bit i, with cin folded into bit 0
    always_comb begin
        prop  = a ^ b;
        gg    = a & b;
        pp    = prop;
        gg[0] = gg[0] | (pp[0] & cin);
        for (int l = 0; l < 5; l++) begin
            for (int i = (2 << l) - 1; i < 32; i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
        for (int l = 3; l >= 0; l--) begin
            for (int i = 3 * (1 << l) - 1; i < 32; i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
    end

    assign sum  = prop ^ {gg[30:0], cin};
    assign cout = gg[31];
endmodule

// File: rtl/seq_booth_mul32.sv
// Multi-cycle signed 32x32->64 radix-2 Booth multiplier, one step per clock.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips the Booth steps (latency 1).
`timescale 1ns/1ps
module seq_booth_mul32
    import mul_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic signed [MUL_W-1:0]    a,
    input  logic signed [MUL_W-1:0]    b,
    output logic                       busy,
    output logic                       done,
    output logic signed [2*MUL_W-1:0]  product
);
    mul_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic signed [2*MUL_W-1:0]  product_q, product_d;

    logic signed [MUL_W-1:0]    m_q, m_d;
    logic signed [MUL_W:0]      acc_q, acc_d;
    logic [MUL_W-1:0]           q_q, q_d;
    logic                       qm1_q, qm1_d;

    logic                       add_en;
    logic                       sub_en;
    logic [MUL_W:0]             mx;
    logic [MUL_W-1:0]           add_sum;
    logic                       add_cout;
    logic signed [MUL_W:0]      acc_step;

    assign add_en = q_q[0] ^ qm1_q;
    assign sub_en = q_q[0] & ~qm1_q;
    assign mx     = sub_en ? ~{m_q[MUL_W-1], m_q} : {m_q[MUL_W-1], m_q};

    bk_adder32 u_adder (
        .a    (acc_q[MUL_W-1:0]),
        .b    (mx[MUL_W-1:0]),
        .cin  (sub_en),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Bit 32 is recovered from the adder carry so -2^31 operands cannot overflow
    assign acc_step = add_en ? {acc_q[MUL_W] ^ mx[MUL_W] ^ add_cout, add_sum} : acc_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        product_d = product_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = a;
                    acc_d   = '0;
                    q_d     = b;
                    qm1_d   = 1'b0;
                    count_d = '0;
                    state_d = S_RUN;
`ifdef MUL_ZERO_BYPASS_EN
                    if (a == '0 || b == '0) begin
                        state_d   = S_DONE;
                        product_d = '0;
                    end
`endif
                end
            end
            S_RUN: begin
                acc_d   = {acc_step[MUL_W], acc_step[MUL_W:1]};
                q_d     = {acc_step[0], q_q[MUL_W-1:1]};
                qm1_d   = q_q[0];
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(MUL_STEPS - 1)) begin
                    state_d   = S_DONE;
                    product_d = {acc_d[MUL_W-1:0], q_d};
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    // Working registers need no reset: they are always loaded on start
    always_ff @(posedge clk) begin
        m_q   <= m_d;
        acc_q <= acc_d;
        q_q   <= q_d;
        qm1_q <= qm1_d;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_seq_booth_mul32.sv
// Directed self-checking bench for seq_booth_mul32 (honours MUL_ZERO_BYPASS_EN).
`timescale 1ns/1ps
module tb_seq_booth_mul32;
    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [31:0] a_i;
    logic signed [31:0] b_i;
    logic               busy;
    logic               done;
    logic signed [63:0] product;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seq_booth_mul32 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a_i),
        .b       (b_i),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one start pulse from IDLE and wait for done; lat counts edges from acceptance
    task automatic run_mul(input logic [31:0] ai, input logic [31:0] bi,
                           output logic [63:0] prod, output int lat, output int bcnt);
        @(negedge clk);
        a_i = ai; b_i = bi; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (busy) bcnt++;
        prod = product;
    endtask

    task automatic mul_check(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                             input logic [63:0] exp);
        logic [63:0] p;
        int lat, bc;
        run_mul(ai, bi, p, lat, bc);
        chk(tag, p, exp);
    endtask

    task automatic wait_done(input string tag, output int t);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {63'd0, done}, 64'd1);
        t = cyc;
    endtask

    initial begin
        logic [63:0] p;
        int lat, bc, t1, t2, ndone;
        logic [31:0] ra, rb;
        longint e;

        rst_n = 1'b0; start = 1'b0; a_i = '0; b_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_product", product, 64'd0);
        rst_n = 1'b1;

        run_mul(32'd7, -32'sd3, p, lat, bc);
        chk("7x-3", p, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("7x-3_latency", 64'(lat), 64'd33);
        chk("7x-3_busy_cycles", 64'(bc), 64'd33);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("busy_after_done", {63'd0, busy}, 64'd0);
        chk("product_held", product, 64'hFFFF_FFFF_FFFF_FFEB);

        mul_check("min_x_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        mul_check("min_x_1", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
        mul_check("max_x_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        mul_check("max_x_min", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        mul_check("m1_x_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            e = longint'($signed(ra)) * longint'($signed(rb));
            mul_check("random", ra, rb, e);
        end

        // start re-pulsed mid-run and in the DONE cycle must be ignored
        @(negedge clk);
        a_i = 32'sd12345; b_i = -32'sd100; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; a_i = 32'sd999; b_i = 32'sd999;
        @(negedge clk);
        start = 1'b0; a_i = 32'sd1; b_i = 32'sd1;
        wait_done("repulse_done", t1);
        chk("repulse_product", product, 64'hFFFF_FFFF_FFED_29BC);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("still_idle", {63'd0, busy}, 64'd0);
        chk("repulse_product_held", product, 64'hFFFF_FFFF_FFED_29BC);

        // start held high: back-to-back operations 34 cycles apart
        @(negedge clk);
        a_i = 32'sd3; b_i = 32'sd5; start = 1'b1;
        wait_done("held_done1", t1);
        chk("held_product1", product, 64'd15);
        a_i = 32'sd4;
        @(negedge clk);
        wait_done("held_done2", t2);
        start = 1'b0;
        chk("held_gap", 64'(t2 - t1), 64'd34);
        chk("held_product2", product, 64'd20);
        repeat (2) @(negedge clk);
        chk("held_stop_idle", {63'd0, busy}, 64'd0);

        // asynchronous reset mid-run
        @(negedge clk);
        a_i = 32'sd3; b_i = 32'sd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_done", {63'd0, done}, 64'd0);
        chk("async_rst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("no_done_after_abort", 64'(ndone), 64'd0);
        mul_check("after_reset", -32'sd5, 32'sd6, 64'hFFFF_FFFF_FFFF_FFE2);

        run_mul(32'd0, 32'd5, p, lat, bc);
        chk("zero_product", p, 64'd0);
`ifdef MUL_ZERO_BYPASS_EN
        chk("zero_latency", 64'(lat), 64'd1);
`else
        chk("zero_latency", 64'(lat), 64'd33);
`endif
        @(negedge clk);
        chk("zero_done_pulse", {63'd0, done}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
